// File: rtl/pll_spi_pkg.sv
// Shared types and constants for the PLL SPI engine arbiter.
package pll_spi_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Read data returned to a requester whose transaction was aborted by timeout.
    localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/pll_spi_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_grant, wrapping modulo NREQ.
module pll_spi_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             found,
    output logic [IDX_W-1:0] winner
);
    import pll_spi_pkg::*;

    // Scan from the farthest candidate back to the nearest so the nearest one wins.
    always_comb begin
        found  = |req;
        winner = '0;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(last_grant) + k) % NREQ;
            if (req[idx]) begin
                winner = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pll_spi_arbiter.sv
// Round-robin arbiter sharing one PLL SPI register engine between NREQ requesters.
// Optional WAIT timeout abort is enabled by defining PLL_SPI_ARB_TIMEOUT_EN.
module pll_spi_arbiter
    import pll_spi_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     if_read,
    output logic                     if_write,
    output logic [ADDR_W-1:0]        if_addr,
    output logic [DATA_W-1:0]        if_wdata,
    output logic                     if_reset,
    input  logic                     if_done,
    input  logic [DATA_W-1:0]        if_rdata,
    output logic [1:0]               dbg_state
);
    // Handshake: req_valid[i] and its fields stay stable until the one-cycle
    // req_ready[i] pulse; rsp_valid[i] pulses once per accepted command and
    // carries rsp_rdata/rsp_err in that same cycle.
    localparam int IDX_W = $clog2(NREQ);

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    pll_spi_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .found      (pick_found),
        .winner     (pick_idx)
    );

    assign dbg_state = state;

`ifdef PLL_SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NREQ - 1);
            grant      <= '0;
            if_read    <= 1'b0;
            if_write   <= 1'b0;
            if_addr    <= '0;
            if_wdata   <= '0;
            if_reset   <= 1'b1;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            busy       <= 1'b0;
`ifdef PLL_SPI_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant      <= pick_idx;
                        last_grant <= pick_idx;
                        if_write   <= req_write[pick_idx];
                        if_read    <= ~req_write[pick_idx];
                        if_addr    <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        if_wdata   <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        req_ready  <= NREQ'(1) << pick_idx;
                        busy       <= 1'b1;
                        state      <= ISSUE;
`ifdef PLL_SPI_ARB_TIMEOUT_EN
                        wait_cnt   <= CNT_W'(TIMEOUT);
`endif
                    end
                end
                ISSUE: begin
                    if_reset <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (if_done) begin
                        rsp_valid <= NREQ'(1) << grant;
                        if (!if_write) begin
                            rsp_rdata <= if_rdata;
                        end
                        if_reset  <= 1'b1;
                        state     <= RELEASE;
`ifdef PLL_SPI_ARB_TIMEOUT_EN
                        rsp_err_q <= 1'b0;
                    end else if (wait_cnt <= CNT_W'(1)) begin
                        rsp_valid <= NREQ'(1) << grant;
                        rsp_rdata <= TIMEOUT_RDATA;
                        rsp_err_q <= 1'b1;
                        if_reset  <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        wait_cnt  <= wait_cnt - CNT_W'(1);
`endif
                    end
                end
                RELEASE: begin
                    // The engine holds if_done until it sees if_reset high; never start a new command over a stale done.
                    if (!if_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_spi_arbiter.sv
// Self-checking bench for pll_spi_arbiter: directed scenarios, an engine model and a per-cycle reference model.
module tb_pll_spi_arbiter;
    import pll_spi_pkg::*;

    localparam int NREQ    = 4;
    localparam int TO_CYC  = 16;
    localparam int P_FREE  = 0;
    localparam int P_ACT   = 1;
    localparam int P_DRAIN = 2;

    // clock / reset
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_write = '0;
    logic [NREQ*8-1:0] req_addr  = '0;
    logic [NREQ*8-1:0] req_wdata = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              if_read;
    logic              if_write;
    logic [7:0]        if_addr;
    logic [7:0]        if_wdata;
    logic              if_reset;
    logic              if_done  = 1'b0;
    logic [7:0]        if_rdata = 8'h00;
    logic [1:0]        dbg_state;

    pll_spi_arbiter #(.NREQ(NREQ), .TIMEOUT(TO_CYC)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .if_read   (if_read),
        .if_write  (if_write),
        .if_addr   (if_addr),
        .if_wdata  (if_wdata),
        .if_reset  (if_reset),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .dbg_state (dbg_state)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int grant_log[$];

    int         eng_lat  = 10;
    int         eng_hold = 0;
    bit         eng_mute = 1'b0;
    logic [7:0] eng_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic post(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d);
        req_write[i]         = wr;
        req_addr[i*8 +: 8]   = a;
        req_wdata[i*8 +: 8]  = d;
        req_valid[i]         = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_bit(input bit rsp, input int i, input int max, output int at);
        at = -1;
        for (int n = 0; n < max; n++) begin
            if ((rsp ? rsp_valid[i] : req_ready[i]) === 1'b1) begin
                at = cyc;
                return;
            end
            @(negedge clk);
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_%s[%0d]: not seen within %0d cycles", rsp ? "rsp" : "ready", i, max);
    endtask

    task automatic wait_idle(input int max);
        for (int n = 0; n < max; n++) begin
            if (req_valid == '0 && busy === 1'b0) return;
            @(negedge clk);
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_idle: still busy after %0d cycles", max);
    endtask

    function automatic logic [31:0] log_word();
        logic [31:0] r;
        r = 32'h0;
        foreach (grant_log[k]) r = (r << 4) | 32'(grant_log[k] & 15);
        return r;
    endfunction

    // engine model: done after eng_lat cycles of run, held eng_hold cycles past if_reset rising
    initial begin : engine
        bit abort;
        int guard;
        forever begin
            @(negedge clk);
            if (reset || if_reset !== 1'b0) continue;
            if (eng_mute) begin
                guard = 0;
                while (if_reset === 1'b0 && guard < 10000) begin
                    @(negedge clk);
                    guard++;
                end
                continue;
            end
            abort = 1'b0;
            for (int k = 1; k < eng_lat; k++) begin
                @(negedge clk);
                if (if_reset !== 1'b0) begin
                    abort = 1'b1;
                    break;
                end
            end
            if (abort) continue;
            if_done  = 1'b1;
            if_rdata = eng_data;
            guard = 0;
            while (if_reset === 1'b0 && guard < 10000) begin
                @(negedge clk);
                guard++;
            end
            repeat (eng_hold) @(negedge clk);
            if_done = 1'b0;
        end
    end

    // scoreboard: abstract transaction model checked against the DUT every cycle
    initial begin : compare
        int phase, grant_m, last_m, issue_c, w;
        logic [NREQ-1:0] s_valid, e_ready, e_rsp;
        logic s_done, s_reset, e_err, m_wr, m_rd;
        logic [7:0] s_rdata, m_addr, m_wdata, m_rdata;
        phase = P_FREE; last_m = NREQ - 1; grant_m = 0; issue_c = 0;
        m_wr = 0; m_rd = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
        forever begin
            @(posedge clk);
            cyc++;
            s_valid = req_valid;
            s_done  = if_done;
            s_rdata = if_rdata;
            s_reset = reset;
            @(negedge clk);
            if (reset || s_reset) begin
                phase = P_FREE; last_m = NREQ - 1;
                m_wr = 0; m_rd = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
                continue;
            end
            e_ready = '0;
            e_rsp   = '0;
            e_err   = 1'b0;
            case (phase)
                P_FREE: begin
                    if (s_valid != '0) begin
                        w = -1;
                        for (int k = 1; k <= NREQ; k++) begin
                            if (w < 0 && s_valid[(last_m + k) % NREQ]) w = (last_m + k) % NREQ;
                        end
                        e_ready[w] = 1'b1;
                        grant_m = w;
                        last_m  = w;
                        issue_c = cyc;
                        phase   = P_ACT;
                        m_wr    = req_write[w];
                        m_rd    = ~req_write[w];
                        m_addr  = req_addr[w*8 +: 8];
                        m_wdata = req_wdata[w*8 +: 8];
                        grant_log.push_back(w);
                    end
                end
                P_ACT: begin
                    if (s_done) begin
                        e_rsp[grant_m] = 1'b1;
                        if (!m_wr) m_rdata = s_rdata;
                        phase = P_DRAIN;
                    end
`ifdef PLL_SPI_ARB_TIMEOUT_EN
                    else if (cyc - issue_c == TO_CYC + 1) begin
                        e_rsp[grant_m] = 1'b1;
                        e_err   = 1'b1;
                        m_rdata = 8'hFF;
                        phase   = P_DRAIN;
                    end
`endif
                end
                P_DRAIN: begin
                    if (!s_done) phase = P_FREE;
                end
                default: ;
            endcase
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            chk("busy", 32'(busy), 32'(phase != P_FREE));
            chk("if_reset", 32'(if_reset), 32'(!(phase == P_ACT && cyc != issue_c)));
            chk("if_read", 32'(if_read), 32'(m_rd));
            chk("if_write", 32'(if_write), 32'(m_wr));
            chk("if_addr", 32'(if_addr), 32'(m_addr));
            chk("if_wdata", 32'(if_wdata), 32'(m_wdata));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
            if (e_rsp != '0) chk("rsp_err", 32'(rsp_err), 32'(e_err));
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] === 1'b1) req_valid[i] = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t0, t1;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst if_reset", 32'(if_reset), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst if_rw", 32'({if_read, if_write}), 32'd0);
        chk("rst if_addr", 32'(if_addr), 32'd0);
        chk("rst if_wdata", 32'(if_wdata), 32'd0);
        chk("rst rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        chk("rst state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;

        // single read
        eng_lat = 10; eng_data = 8'hA5;
        @(negedge clk);
        post(0, 1'b0, 8'h02, 8'h00);
        wait_bit(1'b0, 0, 20, t0);
        chk("rd ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        chk("rd if_read", 32'(if_read), 32'd1);
        chk("rd if_addr", 32'(if_addr), 32'h02);
        chk("rd if_reset", 32'(if_reset), 32'd0);
        wait_bit(1'b1, 0, 50, t1);
        chk("rd rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rd rsp_rdata", 32'(rsp_rdata), 32'hA5);
        chk("rd rsp_err", 32'(rsp_err), 32'd0);
        chk("rd latency", 32'(t1 - t0), 32'd11);
        wait_idle(50);

        // contention from reset, then re-requests
        pulse_reset();
        grant_log.delete();
        eng_lat = 3; eng_data = 8'h3C;
        @(negedge clk);
        post(0, 1'b0, 8'h10, 8'h00);
        post(1, 1'b1, 8'h11, 8'h61);
        post(2, 1'b0, 8'h12, 8'h00);
        post(3, 1'b0, 8'h13, 8'h00);
        wait_idle(200);
        chk("contention order", log_word(), 32'h0123);
        grant_log.delete();
        @(negedge clk);
        post(1, 1'b0, 8'h21, 8'h00);
        post(3, 1'b0, 8'h23, 8'h00);
        wait_idle(200);
        chk("rerequest order", log_word(), 32'h13);

        // write keeps previous read data
        @(negedge clk);
        post(2, 1'b1, 8'h2B, 8'h0A);
        wait_bit(1'b0, 2, 20, t0);
        @(negedge clk);
        chk("wr if_write", 32'(if_write), 32'd1);
        chk("wr if_read", 32'(if_read), 32'd0);
        chk("wr if_wdata", 32'(if_wdata), 32'h0A);
        chk("wr if_addr", 32'(if_addr), 32'h2B);
        wait_bit(1'b1, 2, 50, t1);
        chk("wr keeps rdata", 32'(rsp_rdata), 32'h3C);
        wait_idle(50);

        // slow if_done release holds off the next grant
        eng_hold = 5; eng_data = 8'h77;
        @(negedge clk);
        post(1, 1'b0, 8'h40, 8'h00);
        wait_bit(1'b0, 1, 20, t0);
        @(negedge clk);
        post(0, 1'b0, 8'h41, 8'h00);
        wait_bit(1'b1, 1, 50, t1);
        wait_bit(1'b0, 0, 50, t0);
        chk("release gap", 32'(t0 - t1), 32'd7);
        eng_hold = 0;
        wait_idle(50);

        // reset in the middle of WAIT
        eng_lat = 10;
        @(negedge clk);
        post(2, 1'b0, 8'h50, 8'h00);
        wait_bit(1'b0, 2, 20, t0);
        repeat (3) @(negedge clk);
        chk("pre-reset if_reset", 32'(if_reset), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("mid-rst if_reset", 32'(if_reset), 32'd1);
        chk("mid-rst busy", 32'(busy), 32'd0);
        chk("mid-rst rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        grant_log.delete();
        eng_lat = 4;
        @(negedge clk);
        post(1, 1'b0, 8'h61, 8'h00);
        post(0, 1'b0, 8'h60, 8'h00);
        wait_idle(100);
        chk("post-reset order", log_word(), 32'h01);

`ifdef PLL_SPI_ARB_TIMEOUT_EN
        // engine never completes
        eng_mute = 1'b1;
        @(negedge clk);
        post(3, 1'b0, 8'h70, 8'h00);
        wait_bit(1'b0, 3, 20, t0);
        wait_bit(1'b1, 3, 60, t1);
        chk("timeout latency", 32'(t1 - t0), 32'd17);
        chk("timeout rsp_err", 32'(rsp_err), 32'd1);
        chk("timeout rdata", 32'(rsp_rdata), 32'hFF);
        eng_mute = 1'b0;
        wait_idle(50);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
